// File: rtl/p_ssync_vec_filt.sv
// WIDTH-bit, DEPTH-stage synchronizer with per-bit reset value and rise/fall/any-change pulses.
// Define SSYNC_VEC_STABLE_FILTER_EN to add the whole-vector stability filter in front of q.
module p_ssync_vec_filt #(
  parameter int               WIDTH    = 1,
  parameter int               DEPTH    = 3,
  parameter logic [WIDTH-1:0] INIT     = {WIDTH{1'b1}},
  parameter int               FILT_CNT = 4,
  parameter int               CNT_W    = 3
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             chg,
  output logic             stable
);

  if (DEPTH < 2 || DEPTH > 8) begin : g_bad_depth
    $error("p_ssync_vec_filt: DEPTH must be in 2..8");
  end
  if (FILT_CNT < 1 || FILT_CNT > (1 << CNT_W) - 1) begin : g_bad_filt
    $error("p_ssync_vec_filt: FILT_CNT must be in 1..2^CNT_W-1");
  end

  logic [WIDTH-1:0] s_q [DEPTH];
  logic [WIDTH-1:0] s_d [DEPTH];
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [WIDTH-1:0] sv;

  assign sv = s_q[DEPTH-1];

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      s_d[k] = s_q[k];
    end
    if (en) begin
      s_d[0] = d;
      for (int k = 1; k < DEPTH; k++) begin
        s_d[k] = s_q[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_) begin
      for (int k = 0; k < DEPTH; k++) begin
        s_q[k] <= INIT;
      end
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        s_q[k] <= s_d[k];
      end
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

`ifdef SSYNC_VEC_STABLE_FILTER_EN
  typedef enum logic {IDLE, QUAL} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;

  // A candidate only commits after it has been seen unchanged FILT_CNT+1 enabled edges in a row.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    rise_d  = '0;
    fall_d  = '0;
    if (en) begin
      case (state_q)
        IDLE: begin
          if (sv != q_q) begin
            cand_d  = sv;
            cnt_d   = CNT_W'(1);
            state_d = QUAL;
          end
        end
        QUAL: begin
          if (sv == cand_q) begin
            if (cnt_q == CNT_W'(FILT_CNT)) begin
              q_d     = cand_q;
              rise_d  = cand_q & ~q_q;
              fall_d  = ~cand_q & q_q;
              cnt_d   = '0;
              state_d = IDLE;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else if (sv == q_q) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cand_d = sv;
            cnt_d  = CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_) begin
      state_q <= IDLE;
      cand_q  <= INIT;
      cnt_q   <= '0;
      q_q     <= INIT;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
    end
  end

  assign q      = q_q;
  assign stable = (state_q == IDLE);
`else
  // Edge detect across the last two stages so the pulse lines up with the new q.
  always_comb begin
    rise_d = '0;
    fall_d = '0;
    if (en) begin
      rise_d = s_q[DEPTH-2] & ~s_q[DEPTH-1];
      fall_d = ~s_q[DEPTH-2] & s_q[DEPTH-1];
    end
  end

  assign q      = sv;
  assign stable = 1'b1;
`endif

  assign rise = rise_q;
  assign fall = fall_q;
  assign chg  = |(rise_q | fall_q);

endmodule

// File: tb/tb_p_ssync_vec_filt.sv
// Self-checking bench for p_ssync_vec_filt: run-length reference model plus directed literal checks.
module tb_p_ssync_vec_filt;

  localparam int        W      = 8;
  localparam int        DP     = 3;
  localparam int        FC     = 4;
  localparam int        CW     = 3;
  localparam logic [7:0] INIT_V = 8'hA5;
`ifdef SSYNC_VEC_STABLE_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic         clk;
  logic         reset_;
  logic [W-1:0] d;
  logic         en;
  logic [W-1:0] q;
  logic [W-1:0] rise;
  logic [W-1:0] fall;
  logic         chg;
  logic         stable;

  int n_checks = 0;
  int n_fail   = 0;

  p_ssync_vec_filt #(
    .WIDTH(W), .DEPTH(DP), .INIT(INIT_V), .FILT_CNT(FC), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset_(reset_), .d(d), .en(en),
    .q(q), .rise(rise), .fall(fall), .chg(chg), .stable(stable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: samples delayed through a DP-deep sample history; the filter is a
  // run-length count of identical sv values that differ from q.
  logic [W-1:0] m_hist[$];
  logic [W-1:0] m_q, m_rise, m_fall, m_run_val;
  int           m_run;
  bit           m_valid = 1'b0;

  task automatic model_step();
    logic [W-1:0] old_sv, old_q;
    if (!reset_) begin
      m_hist = {};
      for (int i = 0; i < DP; i++) m_hist.push_back(INIT_V);
      m_q = INIT_V; m_rise = '0; m_fall = '0; m_run = 0; m_run_val = INIT_V;
      m_valid = 1'b1;
    end else if (m_valid) begin
      if (!en) begin
        m_rise = '0; m_fall = '0;
      end else begin
        old_sv = m_hist[0];
        old_q  = m_q;
        m_hist.push_back(d);
        void'(m_hist.pop_front());
        if (FILT) begin
          if (old_sv == m_q) m_run = 0;
          else if (m_run > 0 && old_sv == m_run_val) m_run++;
          else begin m_run_val = old_sv; m_run = 1; end
          if (m_run == FC + 1) begin m_q = m_run_val; m_run = 0; end
        end else begin
          m_q = m_hist[0];
        end
        m_rise = m_q & ~old_q;
        m_fall = ~m_q & old_q;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      if (m_valid) begin
        chk("model_q", 32'(q), 32'(m_q));
        chk("model_rise", 32'(rise), 32'(m_rise));
        chk("model_fall", 32'(fall), 32'(m_fall));
        chk("model_chg", 32'(chg), 32'(|(m_rise | m_fall)));
        chk("model_stable", 32'(stable), FILT ? 32'(m_run == 0) : 32'd1);
      end
    end
  end

  task automatic step(input logic [W-1:0] dv, input logic ev, input logic rv);
    d = dv; en = ev; reset_ = rv;
    @(negedge clk);
  endtask

  int lat;
  int rise_cycles;

  initial begin
    d = 8'h5A; en = 1'b1; reset_ = 1'b0;
    // Reset held two cycles with d opposite to INIT; second cycle also has en low.
    step(8'h5A, 1'b1, 1'b0);
    step(8'h5A, 1'b0, 1'b0);
    chk("rst_q", 32'(q), 32'hA5);
    chk("rst_rise", 32'(rise), 32'h0);
    chk("rst_fall", 32'(fall), 32'h0);
    chk("rst_chg", 32'(chg), 32'h0);
    chk("rst_stable", 32'(stable), 32'h1);
    for (int k = 0; k < 6; k++) begin
      step(8'hA5, 1'b1, 1'b1);
      chk("post_rst_q", 32'(q), 32'hA5);
      chk("post_rst_chg", 32'(chg), 32'h0);
    end

    // Latency: d captured at edge 0.
    lat = FILT ? 7 : 2;
    for (int k = 0; k < 10; k++) begin
      step(8'h5A, 1'b1, 1'b1);
      chk("lat_q", 32'(q), (k >= lat) ? 32'h5A : 32'hA5);
      chk("lat_rise", 32'(rise), (k == lat) ? 32'h5A : 32'h0);
      chk("lat_fall", 32'(fall), (k == lat) ? 32'hA5 : 32'h0);
      chk("lat_stable", 32'(stable), (FILT && k >= 3 && k < 7) ? 32'h0 : 32'h1);
    end

    // Glitch: two-cycle excursion back to A5.
    step(8'hA5, 1'b1, 1'b1);
    step(8'hA5, 1'b1, 1'b1);
    for (int k = 0; k < 10; k++) begin
      step(8'h5A, 1'b1, 1'b1);
      if (FILT) begin
        chk("glitch_q", 32'(q), 32'h5A);
        chk("glitch_chg", 32'(chg), 32'h0);
      end
    end
    chk("glitch_end_q", 32'(q), 32'h5A);

    // Skewed bus 00 -> FF over three cycles.
    repeat (10) step(8'h00, 1'b1, 1'b1);
    chk("skew_start_q", 32'(q), 32'h00);
    rise_cycles = 0;
    for (int k = 0; k < 14; k++) begin
      if (k == 0) step(8'h0F, 1'b1, 1'b1);
      else if (k == 1) step(8'h3F, 1'b1, 1'b1);
      else step(8'hFF, 1'b1, 1'b1);
      if (rise != 8'h00) rise_cycles++;
      if (FILT) begin
        chk("skew_coherent", 32'(q == 8'h00 || q == 8'hFF), 32'h1);
        chk("skew_q_at", 32'(q), (k >= 9) ? 32'hFF : 32'h00);
      end
    end
    chk("skew_end_q", 32'(q), 32'hFF);
    if (FILT) chk("skew_rise_cycles", 32'(rise_cycles), 32'd1);

    // Enable drop while qualifying FF -> 00 (cnt=2 after edge 4).
    repeat (5) step(8'h00, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      step(8'h00, 1'b0, 1'b1);
      chk("en_hold_chg", 32'(chg), 32'h0);
      if (FILT) begin
        chk("en_hold_q", 32'(q), 32'hFF);
        chk("en_hold_stable", 32'(stable), 32'h0);
      end
    end
    for (int k = 0; k < 5; k++) begin
      step(8'h00, 1'b1, 1'b1);
      if (FILT) begin
        chk("en_resume_q", 32'(q), (k >= 2) ? 32'h00 : 32'hFF);
        chk("en_resume_fall", 32'(fall), (k == 2) ? 32'hFF : 32'h0);
      end
    end
    chk("en_end_q", 32'(q), 32'h00);

    // Reset while qualifying 00 -> FF (cnt=3 after edge 5).
    repeat (6) step(8'hFF, 1'b1, 1'b1);
    if (FILT) begin
      chk("mid_rst_pre_q", 32'(q), 32'h00);
      chk("mid_rst_pre_stable", 32'(stable), 32'h0);
    end
    step(8'hFF, 1'b1, 1'b0);
    chk("mid_rst_q", 32'(q), 32'hA5);
    chk("mid_rst_chg", 32'(chg), 32'h0);
    chk("mid_rst_stable", 32'(stable), 32'h1);
    for (int k = 0; k < 8; k++) begin
      step(8'hA5, 1'b1, 1'b1);
      chk("mid_rst_after_q", 32'(q), 32'hA5);
      chk("mid_rst_after_chg", 32'(chg), 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
